fp_addsub_ctrl: RTL and testbench

FP_ADDSUB_CTRL -- requirements
Module: fp_addsub_ctrl

---
 rtl/fp_addsub_ctrl.sv | 169 ++++++++++++++++
 tb/tb_fp_addsub_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fp_addsub_ctrl
// Brief    : Multi-cycle IEEE754 single-precision adder/subtractor with a
//            valid/ready handshake on operands and result (truncating).
// Revision : 1.0 - initial release
// ============================================================================
module fp_addsub_ctrl #(
    parameter int SHIFT_LIMIT = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op,
    output logic [31:0] result,
    output logic        result_valid,
    input  logic        result_ready,
    output logic        busy
);

    localparam logic [8:0]  c_SHIFT_LIM = SHIFT_LIMIT[8:0];
    localparam logic [31:0] c_QNAN      = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EXP   = 3'd1,
        S_ALIGN = 3'd2,
        S_ADD   = 3'd3,
        S_NORM  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_op;
    logic        r_sa;
    logic        r_sb;
    logic [7:0]  r_ea;
    logic [23:0] r_fa;
    logic [23:0] r_fb;
    logic [7:0]  r_diff;
    logic        r_nan;
    logic [24:0] r_sum;
    logic [7:0]  r_exp;
    logic [31:0] r_result;

    logic [7:0]  w_ea;
    logic [7:0]  w_eb;
    logic [23:0] w_fa;
    logic [23:0] w_fb;
    logic        w_sb_eff;
    logic        w_swap;
    logic        w_nan;
    logic        w_norm_exit;

    // Zero exponent flushes the operand (denormals included) to zero.
    assign w_ea     = r_a[30:23];
    assign w_eb     = r_b[30:23];
    assign w_fa     = (w_ea == 8'd0) ? 24'd0 : {1'b1, r_a[22:0]};
    assign w_fb     = (w_eb == 8'd0) ? 24'd0 : {1'b1, r_b[22:0]};
    assign w_sb_eff = r_b[31] ^ r_op;
    assign w_swap   = (w_eb > w_ea) || ((w_eb == w_ea) && (w_fb > w_fa));
    assign w_nan    = (w_ea == 8'hFF) || (w_eb == 8'hFF);

    assign w_norm_exit = r_nan || r_sum[24] || r_sum[23] ||
                         (r_sum == 25'd0) || (r_exp == 8'd1);

    assign start_ready  = (r_state == S_IDLE);
    assign busy         = (r_state != S_IDLE);
    assign result_valid = (r_state == S_DONE);
    assign result       = r_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start_valid) w_next = S_EXP;
            S_EXP:   w_next = S_ALIGN;
            S_ALIGN: w_next = S_ADD;
            S_ADD:   w_next = S_NORM;
            S_NORM:  if (w_norm_exit) w_next = S_DONE;
            S_DONE:  if (result_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_op     <= 1'b0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_ea     <= 8'd0;
            r_fa     <= 24'd0;
            r_fb     <= 24'd0;
            r_diff   <= 8'd0;
            r_nan    <= 1'b0;
            r_sum    <= 25'd0;
            r_exp    <= 8'd0;
            r_result <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        r_a  <= a;
                        r_b  <= b;
                        r_op <= op;
                    end
                end
                S_EXP: begin
                    r_sa   <= w_swap ? w_sb_eff : r_a[31];
                    r_sb   <= w_swap ? r_a[31] : w_sb_eff;
                    r_ea   <= w_swap ? w_eb : w_ea;
                    r_fa   <= w_swap ? w_fb : w_fa;
                    r_fb   <= w_swap ? w_fa : w_fb;
                    r_diff <= w_swap ? (w_eb - w_ea) : (w_ea - w_eb);
                    r_nan  <= w_nan;
                end
                S_ALIGN: begin
                    r_fb <= ({1'b0, r_diff} >= c_SHIFT_LIM) ? 24'd0 : (r_fb >> r_diff);
                end
                S_ADD: begin
                    r_sum <= (r_sa == r_sb) ? ({1'b0, r_fa} + {1'b0, r_fb})
                                            : ({1'b0, r_fa} - {1'b0, r_fb});
                    r_exp <= r_ea;
                end
                S_NORM: begin
                    if (r_nan) begin
                        r_result <= c_QNAN;
                    end else if (r_sum[24]) begin
                        // Carry out: an incremented exponent of 255 saturates to infinity.
                        if (r_exp == 8'hFE) begin
                            r_result <= {r_sa, 8'hFF, 23'd0};
                        end else begin
                            r_result <= {r_sa, r_exp + 8'd1, r_sum[23:1]};
                        end
                    end else if (r_sum[23]) begin
                        r_result <= {r_sa, r_exp, r_sum[22:0]};
                    end else if (r_sum == 25'd0) begin
                        r_result <= 32'd0;
                    end else if (r_exp == 8'd1) begin
                        r_result <= {r_sa, 31'd0};
                    end else begin
                        r_sum <= r_sum << 1;
                        r_exp <= r_exp - 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_addsub_ctrl
// Brief    : Directed vector table plus handshake/stall/reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_addsub_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] result;
    logic        result_valid;
    logic        result_ready;
    logic        busy;

    int total = 0;
    int bad   = 0;

    fp_addsub_ctrl #(.SHIFT_LIMIT(25)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .a            (a),
        .b            (b),
        .op           (op),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] r;
        int          k;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Starts one operation from IDLE and returns the cycle index (1 = EXP)
    // at which result_valid is first seen high; 0 if it never appears.
    task automatic launch(input logic [31:0] ia, input logic [31:0] ib, input logic iop,
                          input logic hold_start, output int n);
        a = ia;
        b = ib;
        op = iop;
        start_valid = 1'b1;
        @(negedge clk);
        if (hold_start) begin
            a = 32'h7F80_0000;
            b = 32'h3F80_0000;
        end else begin
            start_valid = 1'b0;
        end
        n = 1;
        while (!result_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!result_valid) n = 0;
    endtask

    initial begin
        int n;
        int seen;
        logic [31:0] held;

        vecs[0]  = '{32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1};
        vecs[1]  = '{32'h4040_0000, 32'h4000_0000, 1'b1, 32'h3F80_0000, 2};
        vecs[2]  = '{32'h3F80_0000, 32'h4C00_0000, 1'b0, 32'h4C00_0000, 1};
        vecs[3]  = '{32'h40A0_0000, 32'h40A0_0000, 1'b1, 32'h0000_0000, 1};
        vecs[4]  = '{32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 1};
        vecs[5]  = '{32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 1};
        vecs[6]  = '{32'h3F80_0000, 32'h3FC0_0000, 1'b1, 32'hBF00_0000, 2};
        vecs[7]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1};
        vecs[8]  = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 1};
        vecs[9]  = '{32'h0000_0001, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 1};
        vecs[10] = '{32'hBF80_0000, 32'hBF80_0000, 1'b0, 32'hC000_0000, 1};
        vecs[11] = '{32'h3F80_0000, 32'h4B00_0000, 1'b0, 32'h4B00_0001, 1};
        vecs[12] = '{32'h8080_0001, 32'h8080_0000, 1'b1, 32'h8000_0000, 1};
        vecs[13] = '{32'h3F80_0001, 32'h3F80_0000, 1'b1, 32'h3400_0000, 24};

        rst = 1'b1;
        start_valid = 1'b0;
        result_ready = 1'b0;
        a = 32'd0;
        b = 32'd0;
        op = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_result", result, 32'h0);
        chk("reset_valid", {31'd0, result_valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_start_ready", {31'd0, start_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].op, 1'b0, n);
            chk($sformatf("v%0d_latency", i), n, 4 + vecs[i].k);
            chk($sformatf("v%0d_result", i), result, vecs[i].r);
            result_ready = 1'b1;
            @(negedge clk);
            result_ready = 1'b0;
            chk($sformatf("v%0d_idle", i), {31'd0, start_ready}, 32'd1);
        end

        // Stall in DONE while start_valid stays asserted with other operands.
        launch(32'h4040_0000, 32'h4000_0000, 1'b1, 1'b1, n);
        chk("stall_latency", n, 6);
        held = result;
        chk("stall_result", held, 32'h3F80_0000);
        for (int c = 0; c < 3; c++) begin
            chk("stall_hold_result", result, held);
            chk("stall_hold_valid", {31'd0, result_valid}, 32'd1);
            chk("stall_start_ready", {31'd0, start_ready}, 32'd0);
            @(negedge clk);
        end
        start_valid = 1'b0;
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        chk("release_start_ready", {31'd0, start_ready}, 32'd1);
        chk("release_busy", {31'd0, busy}, 32'd0);
        chk("release_valid", {31'd0, result_valid}, 32'd0);

        // Reset in the middle of a long NORM phase, with start_valid also high.
        a = 32'h3F80_0001;
        b = 32'h3F80_0000;
        op = 1'b1;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        start_valid = 1'b1;
        a = 32'h3F80_0000;
        b = 32'h3F80_0000;
        op = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        start_valid = 1'b0;
        chk("rst_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_start_ready", {31'd0, start_ready}, 32'd1);
        chk("rst_result", result, 32'h0);
        result_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (result_valid || busy) seen = 1;
        end
        result_ready = 1'b0;
        chk("no_stale_result", seen, 0);

        // A fresh operation still works after the aborted one.
        launch(32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0, n);
        chk("post_rst_latency", n, 5);
        chk("post_rst_result", result, 32'h4000_0000);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
